// File: rtl/writeback_queue.sv
// In-order writeback FIFO between the memory stage and the scalar/vector register-file
// write ports. It holds results while the register file stalls and exports per-register
// pending masks to decode.
module writeback_queue #(
  parameter int REG_WIDTH    = 16,
  parameter int LANES        = 4,
  parameter int NUM_REGS     = 16,
  parameter int NUM_VREGS    = 16,
  parameter int DEPTH        = 4,
  parameter int OPCODE_WIDTH = 8,
  parameter int VWIDTH       = REG_WIDTH * LANES,
  parameter int IDX_WIDTH    = $clog2((NUM_REGS > NUM_VREGS) ? NUM_REGS : NUM_VREGS),
  parameter int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_Valid,
  input  logic                    I_WrEn,
  input  logic                    I_IsVector,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [IDX_WIDTH-1:0]    I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_Data,
  input  logic [VWIDTH-1:0]       I_VData,
  input  logic [LANES-1:0]        I_LaneMask,
  input  logic                    I_Stall,
  input  logic                    I_Flush,
  output logic                    O_Ready,
  output logic                    O_WriteBackEnable,
  output logic [IDX_WIDTH-1:0]    O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]    O_WriteBackData,
  output logic                    O_VWriteBackEnable,
  output logic [VWIDTH-1:0]       O_VWriteBackData,
  output logic [LANES-1:0]        O_VWriteBackLaneMask,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [NUM_REGS-1:0]     O_PendingMask,
  output logic [NUM_VREGS-1:0]    O_VPendingMask,
  output logic [CNT_WIDTH-1:0]    O_Count,
  output logic                    O_Overflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [DEPTH-1:0]        vec_q, vec_d;
  logic [IDX_WIDTH-1:0]    idx_q   [DEPTH];
  logic [IDX_WIDTH-1:0]    idx_d   [DEPTH];
  logic [OPCODE_WIDTH-1:0] op_q    [DEPTH];
  logic [OPCODE_WIDTH-1:0] op_d    [DEPTH];
  logic [REG_WIDTH-1:0]    data_q  [DEPTH];
  logic [REG_WIDTH-1:0]    data_d  [DEPTH];
  logic [VWIDTH-1:0]       vdata_q [DEPTH];
  logic [VWIDTH-1:0]       vdata_d [DEPTH];
  logic [LANES-1:0]        mask_q  [DEPTH];
  logic [LANES-1:0]        mask_d  [DEPTH];

  logic                    push_try, push, pop, head_vec;
  logic [PTR_WIDTH-1:0]    slot_off;

  assign O_Ready  = (count_q < CNT_WIDTH'(DEPTH));
  assign push_try = I_Valid && I_WrEn && !I_Flush;
  assign push     = push_try && O_Ready;
  assign pop      = (count_q != '0) && !I_Stall && !I_Flush;
  assign head_vec = vec_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push_try && !O_Ready);
    vec_d      = vec_q;
    idx_d      = idx_q;
    op_d       = op_q;
    data_d     = data_q;
    vdata_d    = vdata_q;
    mask_d     = mask_q;
    if (I_Flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        vec_d[wr_ptr_q]   = I_IsVector;
        idx_d[wr_ptr_q]   = I_DestRegIdx;
        op_d[wr_ptr_q]    = I_Opcode;
        data_d[wr_ptr_q]  = I_Data;
        vdata_d[wr_ptr_q] = I_VData;
        mask_d[wr_ptr_q]  = I_LaneMask;
        wr_ptr_d          = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      vec_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      vec_q      <= vec_d;
    end
  end

  // Payload is qualified by count and pop, so it needs no reset.
  always_ff @(posedge I_CLOCK) begin
    idx_q   <= idx_d;
    op_q    <= op_d;
    data_q  <= data_d;
    vdata_q <= vdata_d;
    mask_q  <= mask_d;
  end

  always_comb begin
    O_WriteBackEnable    = pop && !head_vec;
    O_VWriteBackEnable   = pop && head_vec;
    O_WriteBackRegIdx    = pop ? idx_q[rd_ptr_q] : '0;
    O_Opcode             = pop ? op_q[rd_ptr_q] : '0;
    O_WriteBackData      = O_WriteBackEnable ? data_q[rd_ptr_q] : '0;
    O_VWriteBackData     = O_VWriteBackEnable ? vdata_q[rd_ptr_q] : '0;
    O_VWriteBackLaneMask = O_VWriteBackEnable ? mask_q[rd_ptr_q] : '0;
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    O_PendingMask  = '0;
    O_VPendingMask = '0;
    slot_off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_WIDTH'(i) - rd_ptr_q;
      if (CNT_WIDTH'(slot_off) < count_q) begin
        if (vec_q[i]) begin
          for (int r = 0; r < NUM_VREGS; r++)
            if (idx_q[i] == IDX_WIDTH'(r)) O_VPendingMask[r] = 1'b1;
        end else begin
          for (int r = 0; r < NUM_REGS; r++)
            if (idx_q[i] == IDX_WIDTH'(r)) O_PendingMask[r] = 1'b1;
        end
      end
    end
  end

  assign O_Count    = count_q;
  assign O_Overflow = overflow_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios followed by random traffic, all checked
// each cycle against a queue-based reference model.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst, valid, wren, is_vec, stall, flush;
  logic [7:0]  opcode;
  logic [3:0]  dest, lmask;
  logic [15:0] data;
  logic [63:0] vdata;

  logic        ready, wb_en, vwb_en, ovf;
  logic [3:0]  wb_idx, vwb_mask;
  logic [15:0] wb_data, pend, vpend;
  logic [63:0] vwb_data;
  logic [7:0]  wb_op;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  bit do_check = 1'b0;

  typedef struct {
    logic        vec;
    logic [3:0]  idx;
    logic [7:0]  op;
    logic [15:0] d;
    logic [63:0] vd;
    logic [3:0]  m;
  } ent_t;

  ent_t model_q[$];
  bit   model_ovf = 1'b0;

  always #5 clk = ~clk;

  writeback_queue dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_Valid(valid), .I_WrEn(wren), .I_IsVector(is_vec),
    .I_Opcode(opcode), .I_DestRegIdx(dest), .I_Data(data), .I_VData(vdata),
    .I_LaneMask(lmask), .I_Stall(stall), .I_Flush(flush), .O_Ready(ready),
    .O_WriteBackEnable(wb_en), .O_WriteBackRegIdx(wb_idx), .O_WriteBackData(wb_data),
    .O_VWriteBackEnable(vwb_en), .O_VWriteBackData(vwb_data),
    .O_VWriteBackLaneMask(vwb_mask), .O_Opcode(wb_op), .O_PendingMask(pend),
    .O_VPendingMask(vpend), .O_Count(count), .O_Overflow(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_in();
    valid = 0; wren = 0; is_vec = 0; opcode = '0; dest = '0; data = '0;
    vdata = '0; lmask = '0; flush = 0; rst = 0;
  endtask

  task automatic set_push(input bit v, input logic [3:0] r, input logic [15:0] d,
                          input logic [63:0] vd, input logic [3:0] m, input logic [7:0] op);
    valid = 1; wren = 1; is_vec = v; dest = r; data = d; vdata = vd; lmask = m; opcode = op;
  endtask

  // Inputs are already applied; check this cycle's outputs, then advance the model.
  task automatic cycle();
    bit          exp_pop, full;
    ent_t        h;
    logic [15:0] ep, evp;
    #1;
    full    = (model_q.size() >= 4);
    exp_pop = (model_q.size() != 0) && !stall && !flush;
    ep = '0; evp = '0;
    foreach (model_q[k]) begin
      if (model_q[k].vec) evp[model_q[k].idx] = 1'b1;
      else                ep[model_q[k].idx]  = 1'b1;
    end
    if (exp_pop) h = model_q[0];
    if (do_check) begin
      chk("ready", ready, !full);
      chk("count", count, model_q.size());
      chk("overflow", ovf, model_ovf);
      chk("pend", pend, ep);
      chk("vpend", vpend, evp);
      chk("wb_en", wb_en, exp_pop && !h.vec);
      chk("vwb_en", vwb_en, exp_pop && h.vec);
      chk("wb_idx", wb_idx, exp_pop ? h.idx : 4'h0);
      chk("wb_op", wb_op, exp_pop ? h.op : 8'h0);
      chk("wb_data", wb_data, (exp_pop && !h.vec) ? h.d : 16'h0);
      chk("vwb_data", vwb_data, (exp_pop && h.vec) ? h.vd : 64'h0);
      chk("vwb_mask", vwb_mask, (exp_pop && h.vec) ? h.m : 4'h0);
    end
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (flush) begin
      model_q.delete();
    end else begin
      if (valid && wren && full) model_ovf = 1'b1;
      if (exp_pop) void'(model_q.pop_front());
      if (valid && wren && !full)
        model_q.push_back('{vec: is_vec, idx: dest, op: opcode, d: data, vd: vdata, m: lmask});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    stall = 0;
    rst   = 1;
    cycle();
    cycle();
    idle_in();
    do_check = 1'b1;

    // reset then idle
    repeat (10) cycle();

    // single scalar push, written one cycle later
    set_push(0, 4'd3, 16'h1234, 64'h0, 4'h0, 8'h11);
    cycle();
    idle_in();
    chk("t2_pend_n1", pend, 16'h0008);
    chk("t2_wben_n1", wb_en, 1'b1);
    chk("t2_data_n1", wb_data, 16'h1234);
    cycle();
    chk("t2_pend_n2", pend, 16'h0000);
    cycle();

    // fill under stall, overflow on the fifth push, then drain in order
    stall = 1;
    set_push(0, 4'd1, 16'hA001, 64'h0, 4'h0, 8'h21); cycle();
    set_push(1, 4'd2, 16'h0, 64'h1111_2222_3333_4444, 4'b0100, 8'h22); cycle();
    set_push(0, 4'd1, 16'hA003, 64'h0, 4'h0, 8'h23); cycle();
    set_push(0, 4'd5, 16'hA005, 64'h0, 4'h0, 8'h24); cycle();
    chk("t3_count_full", count, 3'd4);
    chk("t3_ready_full", ready, 1'b0);
    set_push(0, 4'd7, 16'hDEAD, 64'h0, 4'h0, 8'h25); cycle();
    idle_in();
    chk("t3_overflow", ovf, 1'b1);
    stall = 0;
    repeat (5) cycle();

    // steady stream, one push per cycle
    for (int i = 0; i < 20; i++) begin
      set_push(i[0], 4'(i), 16'(16'h5000 + i), {4{16'(i * 3)}}, 4'(i + 1), 8'(i));
      cycle();
      if (i > 0) chk("t4_count", count, 3'd1);
    end
    idle_in();
    cycle();

    // flush with three entries queued
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_push(i == 1, 4'(i + 8), 16'(16'h7700 + i), 64'hFACE_0000 + 64'(i), 4'hF, 8'h40);
      cycle();
    end
    idle_in();
    stall = 0;
    flush = 1;
    chk("t5_no_strobe", wb_en | vwb_en, 1'b0);
    cycle();
    flush = 0;
    chk("t5_count", count, 3'd0);
    chk("t5_masks", {pend, vpend}, 32'h0);
    cycle();

    // reset in the middle of a drain
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_push(0, 4'(i + 12), 16'(16'h9900 + i), 64'h0, 4'h0, 8'h50);
      cycle();
    end
    set_push(0, 4'd1, 16'h1, 64'h0, 4'h0, 8'h0);
    cycle();
    idle_in();
    stall = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_no_strobe", wb_en | vwb_en, 1'b0);
    chk("t6_count", count, 3'd0);
    chk("t6_overflow", ovf, 1'b0);
    cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      valid  = ($urandom_range(0, 99) < 70);
      wren   = ($urandom_range(0, 99) < 85);
      is_vec = 1'($urandom);
      dest   = 4'($urandom);
      data   = 16'($urandom);
      vdata  = {$urandom, $urandom};
      lmask  = 4'($urandom);
      opcode = 8'($urandom);
      stall  = ($urandom_range(0, 99) < 40);
      flush  = ($urandom_range(0, 99) < 3);
      rst    = ($urandom_range(0, 199) == 0);
      cycle();
    end
    idle_in();
    stall = 0;
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
